prog_counter: RTL and testbench

Program counter stage for the S8SP datapath, sitting directly upstream of the address register. It holds the current instruction address and updates it each cycle by increment, absolute jump, signed relative branch, or subroutine call/return. Its output drives the address register's data input, and the control unit pulses the address register's load one cycle after any PC update. An optional hardware return-address stack supports call/return.

---
 rtl/s8sp_pkg.sv | 35 +++
 rtl/pc_ret_stack.sv | 63 ++++++
 rtl/prog_counter.sv | 97 +++++++++
 tb/tb_prog_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/s8sp_pkg.sv
// rtl/s8sp_pkg.sv - shared S8SP address-path constants, PC command encoding and decoder
package s8sp_pkg;

  localparam int ADDR_W         = 8;
  localparam int PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_cmd_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } stk_state_e;

  // Fixed priority: ret > call > load > branch > inc.
  function automatic pc_cmd_e pc_decode(input logic ret, input logic call, input logic load,
                                        input logic branch, input logic inc);
    pc_cmd_e cmd;
    if (ret)         cmd = PC_RET;
    else if (call)   cmd = PC_CALL;
    else if (load)   cmd = PC_LOAD;
    else if (branch) cmd = PC_BRANCH;
    else if (inc)    cmd = PC_INC;
    else             cmd = PC_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - return-address LIFO with EMPTY/PARTIAL/FULL state tracking
import s8sp_pkg::*;

module pc_ret_stack #(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DW-1:0] LAST = DW'(DEPTH - 1);

  stk_state_e       state, state_n;
  logic [DW-1:0]    depth_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (state == ST_FULL);
  assign empty   = (state == ST_EMPTY);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_comb begin
    state_n = state;
    if (do_push)
      state_n = (depth_q == LAST) ? ST_FULL : ST_PARTIAL;
    else if (do_pop)
      state_n = (depth_q == DW'(1)) ? ST_EMPTY : ST_PARTIAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      depth_q <= '0;
    end else begin
      state <= state_n;
      if (do_push)
        depth_q <= depth_q + DW'(1);
      else if (do_pop)
        depth_q <= depth_q - DW'(1);
    end
  end

  // Contents need no reset; the low depth bits wrap to 0 when full, so top index stays valid.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[depth_q[PW-1:0]] <= push_data;
  end

  assign top_data = mem[depth_q[PW-1:0] - PW'(1)];
  assign depth    = depth_q;

endmodule

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - S8SP program counter; return stack built only with PC_CALL_STACK_EN
import s8sp_pkg::*;

module prog_counter #(
  parameter int WIDTH       = ADDR_W,
  parameter int STACK_DEPTH = PC_STACK_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inc_pc,
  input  logic                             load_pc,
  input  logic                             branch_pc,
  input  logic                             call_pc,
  input  logic                             ret_pc,
  input  logic [WIDTH-1:0]                 target_addr,
  input  logic [WIDTH-1:0]                 branch_off,
  input  logic                             clr_err,
  output logic [WIDTH-1:0]                 pc_on_bus,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] ret_addr;
  logic             full, empty;

`ifdef PC_CALL_STACK_EN
  logic ovf_q, unf_q;

  assign cmd = pc_decode(ret_pc, call_pc, load_pc, branch_pc, inc_pc);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd == PC_CALL),
    .pop       (cmd == PC_RET),
    .push_data (pc_q + WIDTH'(1)),
    .top_data  (ret_addr),
    .full      (full),
    .empty     (empty),
    .depth     (stack_depth)
  );

  // A new error in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (cmd == PC_CALL && full) ovf_q <= 1'b1;
      else if (clr_err)           ovf_q <= 1'b0;
      if (cmd == PC_RET && empty) unf_q <= 1'b1;
      else if (clr_err)           unf_q <= 1'b0;
    end
  end

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  logic unused_stack_inputs;

  // Without the stack, call is a plain jump and ret never decodes.
  assign cmd                 = pc_decode(1'b0, call_pc, load_pc, branch_pc, inc_pc);
  assign unused_stack_inputs = ^{ret_pc, clr_err};
  assign full                = 1'b0;
  assign empty               = 1'b1;
  assign ret_addr            = '0;
  assign stack_depth         = '0;
  assign stack_ovf           = 1'b0;
  assign stack_unf           = 1'b0;
`endif

  always_comb begin
    pc_n = pc_q;
    case (cmd)
      PC_INC:    pc_n = pc_q + WIDTH'(1);
      PC_BRANCH: pc_n = pc_q + branch_off;
      PC_LOAD:   pc_n = target_addr;
      PC_CALL:   if (!full)  pc_n = target_addr;
      PC_RET:    if (!empty) pc_n = ret_addr;
      default:   pc_n = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_n;
  end

  assign pc_on_bus = pc_q;

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - self-checking bench for prog_counter, both PC_CALL_STACK_EN builds
module tb_prog_counter;

  localparam int SD = 4;
`ifdef PC_CALL_STACK_EN
  localparam bit HAS_STACK = 1'b1;
`else
  localparam bit HAS_STACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_pc, load_pc, branch_pc, call_pc, ret_pc, clr_err;
  logic [7:0] target_addr, branch_off;
  logic [7:0] pc_on_bus;
  logic [2:0] stack_depth;
  logic       stack_ovf, stack_unf;

  int n_checks = 0;
  int n_errors = 0;

  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  prog_counter #(.WIDTH(8), .STACK_DEPTH(SD)) dut (
    .clk         (clk),
    .reset       (reset),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .branch_pc   (branch_pc),
    .call_pc     (call_pc),
    .ret_pc      (ret_pc),
    .target_addr (target_addr),
    .branch_off  (branch_off),
    .clr_err     (clr_err),
    .pc_on_bus   (pc_on_bus),
    .stack_depth (stack_depth),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_pc", int'(pc_on_bus), m_pc);
    chk("model_depth", int'(stack_depth), m_stk.size());
    chk("model_ovf", int'(stack_ovf), int'(m_ovf));
    chk("model_unf", int'(stack_unf), int'(m_unf));
  end

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one command just after an edge, let the next edge take it, then advance the model.
  task automatic step(input bit r, input bit c, input bit l, input bit b, input bit i,
                      input logic [7:0] t, input logic [7:0] off, input bit clr);
    bit so, su;
    ret_pc = r; call_pc = c; load_pc = l; branch_pc = b; inc_pc = i;
    target_addr = t; branch_off = off; clr_err = clr;
    @(posedge clk);
    #1;
    so = 1'b0;
    su = 1'b0;
    if (HAS_STACK && r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else su = 1'b1;
    end else if (c) begin
      if (!HAS_STACK) m_pc = int'(t);
      else if (m_stk.size() < SD) begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = int'(t);
      end else so = 1'b1;
    end else if (l) m_pc = int'(t);
    else if (b) m_pc = (m_pc + int'(off)) % 256;
    else if (i) m_pc = (m_pc + 1) % 256;
    if (so) m_ovf = 1'b1;
    else if (HAS_STACK && clr) m_ovf = 1'b0;
    if (su) m_unf = 1'b1;
    else if (HAS_STACK && clr) m_unf = 1'b0;
    {ret_pc, call_pc, load_pc, branch_pc, inc_pc, clr_err} = '0;
  endtask

  task automatic do_inc();                    step(0, 0, 0, 0, 1, 8'h00, 8'h00, 0); endtask
  task automatic do_load(input logic [7:0] t); step(0, 0, 1, 0, 0, t, 8'h00, 0); endtask
  task automatic do_call(input logic [7:0] t); step(0, 1, 0, 0, 0, t, 8'h00, 0); endtask
  task automatic do_ret();                    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0); endtask

  initial begin
    reset = 1'b1;
    {ret_pc, call_pc, load_pc, branch_pc, inc_pc, clr_err} = '0;
    target_addr = '0;
    branch_off  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", int'(pc_on_bus), 0);
    chk("reset_depth", int'(stack_depth), 0);
    chk("reset_ovf", int'(stack_ovf), 0);
    chk("reset_unf", int'(stack_unf), 0);
    reset = 1'b0;

    do_inc(); chk("inc1", int'(pc_on_bus), 8'h01);
    do_inc(); chk("inc2", int'(pc_on_bus), 8'h02);
    do_inc(); chk("inc3", int'(pc_on_bus), 8'h03);
    do_load(8'hFF); do_inc(); chk("inc_wrap", int'(pc_on_bus), 8'h00);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 0); chk("hold", int'(pc_on_bus), 8'h00);

    do_load(8'h02); step(0, 0, 0, 1, 0, 8'h00, 8'hFC, 0);
    chk("branch_back", int'(pc_on_bus), 8'hFE);
    do_load(8'hF0); step(0, 0, 0, 1, 0, 8'h00, 8'h20, 0);
    chk("branch_wrap", int'(pc_on_bus), 8'h10);
    step(0, 0, 1, 1, 1, 8'h40, 8'h05, 0); chk("load_wins", int'(pc_on_bus), 8'h40);
    step(0, 0, 0, 1, 1, 8'h00, 8'h05, 0); chk("branch_beats_inc", int'(pc_on_bus), 8'h45);

    do_load(8'h10);
    step(1, 1, 0, 0, 0, 8'h77, 8'h00, 0);
`ifdef PC_CALL_STACK_EN
    chk("callret_ret_wins", int'(pc_on_bus), 8'h10);
    chk("callret_unf", int'(stack_unf), 1);
`else
    chk("callret_is_jump", int'(pc_on_bus), 8'h77);
`endif
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("clr_unf", int'(stack_unf), 0);

    do_load(8'h10);
    do_call(8'h80); do_call(8'h90); do_call(8'hA0); do_call(8'hB0);
    chk("call4_pc", int'(pc_on_bus), 8'hB0);
    do_call(8'hC0);
`ifdef PC_CALL_STACK_EN
    chk("call4_depth", int'(stack_depth), 4);
    chk("ovf_pc_hold", int'(pc_on_bus), 8'hB0);
    chk("ovf_flag", int'(stack_ovf), 1);
    do_ret(); chk("ret1", int'(pc_on_bus), 8'hA1);
    do_ret(); chk("ret2", int'(pc_on_bus), 8'h91);
    do_ret(); chk("ret3", int'(pc_on_bus), 8'h81);
    do_ret(); chk("ret4", int'(pc_on_bus), 8'h11);
    chk("ret_depth0", int'(stack_depth), 0);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("unf_pc_hold", int'(pc_on_bus), 8'h11);
    chk("unf_set_wins", int'(stack_unf), 1);
    chk("ovf_cleared", int'(stack_ovf), 0);
`else
    chk("nostack_call_jump", int'(pc_on_bus), 8'hC0);
    do_ret(); chk("nostack_ret_ignored", int'(pc_on_bus), 8'hC0);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("nostack_unf", int'(stack_unf), 0);
    chk("nostack_ovf", int'(stack_ovf), 0);
`endif
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("clr_alone", int'(stack_unf), 0);

    do_load(8'h20); do_call(8'h50); chk("bb_call", int'(pc_on_bus), 8'h50);
    do_ret();
`ifdef PC_CALL_STACK_EN
    chk("bb_ret", int'(pc_on_bus), 8'h21);
`else
    chk("bb_ret_ignored", int'(pc_on_bus), 8'h50);
`endif

    do_load(8'h30); do_call(8'h40); do_call(8'h55);
    chk("pre_reset_pc", int'(pc_on_bus), 8'h55);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_pc", int'(pc_on_bus), 0);
    chk("async_depth", int'(stack_depth), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_inc(); chk("post_reset_inc", int'(pc_on_bus), 8'h01);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
